// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial adder FSM states and a counter sizing helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A counter always needs at least one bit, even for the smallest widths.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational single-bit full adder used as the serial adder's arithmetic cell.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through a single
// full-adder cell and a registered carry, with a start/busy/done handshake.
import arith_pkg::*;

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic             load, step, last;
  logic [WIDTH-1:0] areg, breg;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_full;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_co;

  fa_bit u_fa (
    .x  (areg[0]),
    .y  (breg[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Newest sum bit enters at the MSB; on the last step this is the complete result.
  assign res_full = {fa_s, res};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          state_n = DONE;
          last    = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_n = RUN;
          load    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Subtraction is a + ~b + ~cin, so B is inverted and the carry seeded with cin ^ sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      areg  <= '0;
      breg  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      busy <= (state_n == RUN);
      done <= (state_n == DONE);
      if (load) begin
        areg  <= a;
        breg  <= sub ? ~b : b;
        carry <= cin ^ sub;
        cnt   <= '0;
      end else if (step) begin
        areg  <= areg >> 1;
        breg  <= breg >> 1;
        carry <= fa_co;
        res   <= res_full[WIDTH-1:1];
        cnt   <= cnt + CW'(1);
        if (last) begin
          sum  <= res_full;
          cout <= fa_co;
          ovf  <= carry ^ fa_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 2 and 64 against an arithmetic reference model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start2, start64;
  logic        sub, cin;
  logic [63:0] a, b;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy2, done2, cout2, ovf2;
  logic [1:0]  sum2;
  logic        busy64, done64, cout64, ovf64;
  logic [63:0] sum64;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  held8 = 8'd0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub), .a(a[1:0]), .b(b[1:0]), .cin(cin),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_adder #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .start(start64), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy64), .done(done64), .sum(sum64), .cout(cout64), .ovf(ovf64)
  );

  // Reference: plain wide unsigned and signed arithmetic on the operand values.
  function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                input logic sv, input logic cv,
                                output logic [63:0] s, output logic co, output logic ov);
    logic [127:0]        mask, ua, ub, uc, t;
    logic signed [127:0] sa, sb, sc, st, hi, lo;
    mask = (128'd1 << w) - 128'd1;
    ua   = {64'd0, av} & mask;
    ub   = {64'd0, bv} & mask;
    uc   = {127'd0, cv};
    if (!sv) begin
      t  = ua + ub + uc;
      co = t[w];
    end else begin
      t  = ua - ub - uc;
      co = (ua >= ub + uc);
    end
    s  = t[63:0] & mask[63:0];
    sa = ua[w-1] ? $signed(ua - (128'd1 << w)) : $signed(ua);
    sb = ub[w-1] ? $signed(ub - (128'd1 << w)) : $signed(ub);
    sc = $signed(uc);
    st = sv ? (sa - sb - sc) : (sa + sb + sc);
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    ov = (st > hi) || (st < lo);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic is_sub, input logic [63:0] av, input logic [63:0] bv,
                               input logic c);
    sub = is_sub;
    a   = av;
    b   = bv;
    cin = c;
  endtask

  task automatic scramble();
    applyStimulus(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
  endtask

  // One 8-bit operation started in the current cycle; returns in the DONE cycle.
  task automatic run8(input logic is_sub, input logic [7:0] av, input logic [7:0] bv,
                      input logic c, input logic [7:0] es, input logic ec, input logic eo,
                      input int pulse_at);
    applyStimulus(is_sub, {56'd0, av}, {56'd0, bv}, c);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    scramble();
    for (int i = 1; i <= 8; i++) begin
      checkOutput("busy8", busy8, 1);
      checkOutput("done8_early", done8, 0);
      checkOutput("hold_sum8", sum8, held8);
      start8 = (i == pulse_at);
      tick();
      start8 = 1'b0;
    end
    checkOutput("done8", done8, 1);
    checkOutput("busy8_done", busy8, 0);
    checkOutput("sum8", sum8, es);
    checkOutput("cout8", cout8, ec);
    checkOutput("ovf8", ovf8, eo);
    held8 = es;
  endtask

  task automatic idle8();
    tick();
    checkOutput("idle_done8", done8, 0);
    checkOutput("idle_busy8", busy8, 0);
    checkOutput("idle_sum8", sum8, held8);
  endtask

  task automatic runRandom8();
    logic [63:0] es;
    logic [7:0]  ra, rb;
    logic        rs, rc, ec, eo;
    ra = 8'($urandom);
    rb = 8'($urandom);
    rs = 1'($urandom);
    rc = 1'($urandom);
    model(8, {56'd0, ra}, {56'd0, rb}, rs, rc, es, ec, eo);
    run8(rs, ra, rb, rc, es[7:0], ec, eo, 0);
    idle8();
  endtask

  // Starts the 2-bit and 64-bit instances together and follows both to completion.
  task automatic runWide(input logic [63:0] av, input logic [63:0] bv,
                         input logic is_sub, input logic c);
    logic [63:0] e2s, e64s;
    logic        e2c, e2o, e64c, e64o;
    model(2, av, bv, is_sub, c, e2s, e2c, e2o);
    model(64, av, bv, is_sub, c, e64s, e64c, e64o);
    applyStimulus(is_sub, av, bv, c);
    start2  = 1'b1;
    start64 = 1'b1;
    tick();
    start2  = 1'b0;
    start64 = 1'b0;
    scramble();
    for (int i = 1; i <= 65; i++) begin
      checkOutput("busy2", busy2, (i <= 2));
      checkOutput("done2", done2, (i == 3));
      checkOutput("busy64", busy64, (i <= 64));
      checkOutput("done64", done64, (i == 65));
      if (i == 3) begin
        checkOutput("sum2", {62'd0, sum2}, e2s);
        checkOutput("cout2", cout2, e2c);
        checkOutput("ovf2", ovf2, e2o);
      end
      if (i == 65) begin
        checkOutput("sum64", sum64, e64s);
        checkOutput("cout64", cout64, e64c);
        checkOutput("ovf64", ovf64, e64o);
      end
      if (i < 65) tick();
    end
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    start8  = 1'b0;
    start2  = 1'b0;
    start64 = 1'b0;
    applyStimulus(1'b0, 64'd0, 64'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_busy8", busy8, 0);
    checkOutput("rst_done8", done8, 0);
    checkOutput("rst_sum8", sum8, 0);
    checkOutput("rst_cout8", cout8, 0);
    checkOutput("rst_ovf8", ovf8, 0);
    checkOutput("rst_sum64", sum64, 0);
    checkOutput("rst_busy2", busy2, 0);
    rst = 1'b0;
    idle8();

    run8(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    idle8();
    run8(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    idle8();
    run8(1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 0);
    idle8();
    run8(1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, 0);
    idle8();
    run8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 0);
    idle8();

    // Mid-run start ignored, then a back-to-back start issued from the DONE cycle.
    run8(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 4);
    run8(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0);
    idle8();

    for (int k = 0; k < 4; k++) runRandom8();

    // Reset asserted in cycle 5 of an operation.
    applyStimulus(1'b0, 64'h11, 64'h22, 1'b0);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      checkOutput("abort_busy8", busy8, 1);
      rst = (i == 5);
      tick();
    end
    rst = 1'b0;
    checkOutput("abort_busy8_cleared", busy8, 0);
    checkOutput("abort_done8", done8, 0);
    checkOutput("abort_sum8", sum8, 0);
    checkOutput("abort_cout8", cout8, 0);
    checkOutput("abort_ovf8", ovf8, 0);
    held8 = 8'd0;
    for (int i = 7; i <= 12; i++) idle8();
    runRandom8();

    for (int k = 0; k < 3; k++)
      runWide({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
